// File: rtl/memory_arbiter.sv
// memory_arbiter: arbitrates an instruction-fetch port and a data port onto a
// single registered RAM port. Data requests win by default. If both are pending
// and the last completed access was data, the instruction request goes first.
// An ERROR from the RAM completes the access with a poison value and sets a
// sticky mem_err flag.
// Optional feature: define MEMORY_ARBITER_TIMEOUT_EN to add an 8-bit wait
// counter. The counter aborts an access after TIMEOUT_CYCLES wait cycles.
// Ports:
//   CLK, nRST                       clock, async active-low reset
//   iREN, iaddr / ihit, iload       instruction request / completion + data
//   dREN, dWEN, daddr, dstore       data request / completion (dhit, dload)
//   ram_ren, ram_wen, ram_addr,     registered RAM command
//   ram_store
//   ram_load, ram_state             RAM read data and status
//   mem_err                         sticky error flag
module memory_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic        ihit,
  output logic        dhit,
  output logic [31:0] iload,
  output logic [31:0] dload,
  output logic        ram_ren,
  output logic        ram_wen,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_store,
  input  logic [31:0] ram_load,
  input  logic [1:0]  ram_state,
  output logic        mem_err
);

  localparam int unsigned DW = 32;
  localparam logic [1:0]    RS_ACCESS = 2'b10;
  localparam logic [1:0]    RS_ERROR  = 2'b11;
  localparam logic [DW-1:0] POISON    = 32'hBAD1BAD1;

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("memory_arbiter: TIMEOUT_CYCLES must be in 1..255");
  end

  typedef enum logic [1:0] {IDLE, DACC, IACC, HIT} state_t;

  state_t        state_q, state_n;
  logic          last_d_q, last_d_n;   // last completed access was data
  logic          op_w_q, op_w_n;       // latched data operation is a write
  logic          ren_n, wen_n, ihit_n, dhit_n, err_n;
  logic [DW-1:0] addr_n, store_n, iload_n, dload_n;
  logic          done, fail;

`ifdef MEMORY_ARBITER_TIMEOUT_EN
  logic [7:0] cnt_q, cnt_n;
`endif

  // Next-state and next-output logic
  always_comb begin
    state_n  = state_q;
    last_d_n = last_d_q;
    op_w_n   = op_w_q;
    ren_n    = ram_ren;
    wen_n    = ram_wen;
    addr_n   = ram_addr;
    store_n  = ram_store;
    ihit_n   = 1'b0;
    dhit_n   = 1'b0;
    iload_n  = iload;
    dload_n  = dload;
    err_n    = mem_err;
    done     = 1'b0;
    fail     = 1'b0;
`ifdef MEMORY_ARBITER_TIMEOUT_EN
    cnt_n    = cnt_q;
`endif
    case (state_q)
      IDLE: begin
        ren_n = 1'b0;
        wen_n = 1'b0;
        // Data first, unless data was served last and an ifetch is waiting
        if ((dREN || dWEN) && !(iREN && last_d_q)) begin
          state_n = DACC;
          op_w_n  = dWEN;
          addr_n  = daddr;
          store_n = dstore;
          ren_n   = ~dWEN;
          wen_n   = dWEN;
`ifdef MEMORY_ARBITER_TIMEOUT_EN
          cnt_n   = 8'd0;
`endif
        end else if (iREN) begin
          state_n = IACC;
          op_w_n  = 1'b0;
          addr_n  = iaddr;
          store_n = dstore;
          ren_n   = 1'b1;
          wen_n   = 1'b0;
`ifdef MEMORY_ARBITER_TIMEOUT_EN
          cnt_n   = 8'd0;
`endif
        end
      end
      DACC, IACC: begin
        if (ram_state == RS_ACCESS) begin
          done = 1'b1;
        end else if (ram_state == RS_ERROR) begin
          fail = 1'b1;
`ifdef MEMORY_ARBITER_TIMEOUT_EN
        end else if (cnt_q == 8'(TIMEOUT_CYCLES - 1)) begin
          fail = 1'b1;
        end else begin
          cnt_n = cnt_q + 8'd1;
`endif
        end
        if (done || fail) begin
          state_n  = HIT;
          ren_n    = 1'b0;
          wen_n    = 1'b0;
          last_d_n = (state_q == DACC);
          dhit_n   = (state_q == DACC);
          ihit_n   = (state_q == IACC);
          if (fail) begin
            err_n = 1'b1;
            if (state_q == DACC) dload_n = POISON;
            else                 iload_n = POISON;
          end else if (state_q == DACC) begin
            if (!op_w_q) dload_n = ram_load;
          end else begin
            iload_n = ram_load;
          end
        end
      end
      HIT: begin
        state_n = IDLE;
        ren_n   = 1'b0;
        wen_n   = 1'b0;
      end
      default: begin
        state_n = IDLE;
        ren_n   = 1'b0;
        wen_n   = 1'b0;
      end
    endcase
  end

  // State and registered outputs
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q   <= IDLE;
      last_d_q  <= 1'b0;
      op_w_q    <= 1'b0;
      ram_ren   <= 1'b0;
      ram_wen   <= 1'b0;
      ram_addr  <= '0;
      ram_store <= '0;
      ihit      <= 1'b0;
      dhit      <= 1'b0;
      iload     <= '0;
      dload     <= '0;
      mem_err   <= 1'b0;
`ifdef MEMORY_ARBITER_TIMEOUT_EN
      cnt_q     <= 8'd0;
`endif
    end else begin
      state_q   <= state_n;
      last_d_q  <= last_d_n;
      op_w_q    <= op_w_n;
      ram_ren   <= ren_n;
      ram_wen   <= wen_n;
      ram_addr  <= addr_n;
      ram_store <= store_n;
      ihit      <= ihit_n;
      dhit      <= dhit_n;
      iload     <= iload_n;
      dload     <= dload_n;
      mem_err   <= err_n;
`ifdef MEMORY_ARBITER_TIMEOUT_EN
      cnt_q     <= cnt_n;
`endif
    end
  end

endmodule

// File: doc/memory_arbiter.md
MEMORY_ARBITER -- requirements
Module: memory_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255: maximum number of cycles spent waiting for ram_state==ACCESS before an access is aborted (range 1..255).
REQ-002 CLK  in  1  single clock; all state updates on the rising edge.
REQ-003 nRST  in  1  reset, asynchronous, active-low.
REQ-004 iREN  in  1  instruction fetch request, held until ihit.
REQ-005 iaddr  in  32  instruction word address.
REQ-006 dREN / dWEN  in  1 each  data read / write request, held until dhit; never both high.
REQ-007 daddr / dstore  in  32 each  data address and write data.
REQ-008 ihit / dhit  out  1 each  one-cycle completion pulses.
REQ-009 iload / dload  out  32 each  registered read data, valid while the matching hit is high.
REQ-010 ram_ren / ram_wen / ram_addr / ram_store  out  1/1/32/32  single RAM port, all registered.
REQ-011 ram_load  in  32  RAM read data.
REQ-012 ram_state  in  2  RAM status: 00 FREE, 01 BUSY, 10 ACCESS, 11 ERROR.
REQ-013 mem_err  out  1  sticky error flag.

Function
REQ-014 The FSM SHALL have four states: IDLE, DACC, IACC, HIT.
- IDLE -> DACC: taken when dREN|dWEN is high.
- IDLE -> IACC: taken when iREN is high and no data request is pending.
REQ-015 On leaving IDLE, the block SHALL latch address, store data and operation; ram_* are driven from the latches from the next cycle onward.
REQ-016 Arbitration SHALL give data priority. Exception: when both are pending and the last completed access was data, the instruction request SHALL go first.
REQ-017 In DACC/IACC, the block SHALL hold the ram_* signals until ram_state==ACCESS is sampled.
- On that edge: capture ram_load into dload or iload, clear ram_ren/ram_wen, and enter HIT.
REQ-018 In HIT, the block SHALL assert exactly one of dhit/ihit for one cycle, then return to IDLE.
- A request still high in that IDLE cycle is treated as new.
REQ-019 Minimum latency SHALL be 2 cycles from the edge that samples the request to the hit cycle, i.e. when RAM returns ACCESS in the first ram_* cycle.
REQ-020 Data writes SHALL pulse dhit; dload is unchanged on a write.
REQ-021 ram_state==ERROR sampled in DACC/IACC SHALL:
- set mem_err;
- load 32'hBAD1BAD1 into the read-data register;
- enter HIT, so the requester never deadlocks.
REQ-022 A request withdrawn mid-access (protocol violation) SHALL still complete the RAM access and pulse its hit.
REQ-023 Address or data changes after latching SHALL be ignored until the next IDLE.
REQ-024 ram_ren and ram_wen SHALL never be high together, and SHALL both be low in IDLE and HIT.

Reset
REQ-025 nRST low SHALL immediately force the following, regardless of clock and mid-access:
- state IDLE;
- ram_ren, ram_wen, ihit, dhit, mem_err all 0;
- ram_addr, ram_store, iload, dload all 32'h0;
- priority history set to "last was instruction";
- timeout counter 0.
REQ-026 After nRST rises, the first request SHALL be sampled on the first rising edge.

Configuration
REQ-027 With macro MEMORY_ARBITER_TIMEOUT_EN defined, an 8-bit counter SHALL run while in DACC/IACC:
- it clears on entry;
- on reaching TIMEOUT_CYCLES without ACCESS or ERROR, the block behaves exactly as REQ-021 (abort, mem_err, HIT).
REQ-028 Without MEMORY_ARBITER_TIMEOUT_EN, no counter SHALL exist and the block waits indefinitely.
- TIMEOUT_CYCLES is ignored.

Verification
REQ-029 dREN=1, daddr=32'h100, ram_state=ACCESS on the 1st ram cycle with ram_load=32'hCAFEF00D -> dhit one cycle, 2 cycles after sampling, with dload=32'hCAFEF00D.
REQ-030 iREN and dWEN rise in the same cycle (daddr 32'h200, dstore 32'h55) -> data write goes first (ram_wen, ram_store=32'h55), then iREN is served, then a held dREN waits behind the instruction.
REQ-031 dREN with ram_state BUSY for 5 cycles then ACCESS -> ram_ren held 6 cycles, dhit on cycle 7, ihit stays 0.
REQ-032 iREN, then ram_state=ERROR -> ihit pulse with iload=32'hBAD1BAD1, mem_err=1 and held through later good accesses until nRST.
REQ-033 nRST pulsed low mid-DACC -> all outputs 0 asynchronously and no hit; a new iREN after release completes normally.
REQ-034 With TIMEOUT_EN, TIMEOUT_CYCLES=4, ram_state stuck BUSY -> abort after 4 wait cycles, hit with 32'hBAD1BAD1 and mem_err=1; without the macro, no hit for 300 cycles.
